// File: rtl/bus_pkg.sv
// Shared bus definitions: select-width helper and the default simple-system address map.
package bus_pkg;

    typedef enum logic [1:0] {
        DEV_RAM     = 2'd0,
        DEV_SIMCTRL = 2'd1,
        DEV_TIMER   = 2'd2
    } bus_dev_e;

    localparam int unsigned NR_SYS_DEVICES = 3;

    localparam logic [31:0] RAM_BASE     = 32'h0020_0000;
    localparam logic [31:0] RAM_MASK     = ~32'h001F_FFFF;
    localparam logic [31:0] SIMCTRL_BASE = 32'h0002_0000;
    localparam logic [31:0] SIMCTRL_MASK = ~32'h0000_03FF;
    localparam logic [31:0] TIMER_BASE   = 32'h0003_0000;
    localparam logic [31:0] TIMER_MASK   = ~32'h0000_03FF;

    // A single port still needs a 1-bit select so the index signals never collapse to zero width.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_prio_arb.sv
// Fixed-priority arbiter: the lowest-indexed requester wins; one-hot grant plus winner index.
module bus_prio_arb
    import bus_pkg::*;
#(
    parameter int unsigned N    = 1,
    parameter int unsigned IdxW = idx_width(N)
) (
    input  logic [N-1:0]    req_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    // Scan from the top down so the lowest-indexed requester is the last one written.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                idx_o    = IdxW'(i);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_interconnect.sv
// Single-cycle multi-host/multi-device interconnect with base/mask decode and N+1 response routing.
// Optional: define BUS_DECODE_ERR_EN to have the bus answer unmatched addresses with an error.
module bus_interconnect
    import bus_pkg::*;
#(
    parameter int unsigned NrDevices    = 1,
    parameter int unsigned NrHosts      = 1,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      host_req_i    [NrHosts],
    output logic                      host_gnt_o    [NrHosts],
    input  logic [AddressWidth-1:0]   host_addr_i   [NrHosts],
    input  logic                      host_we_i     [NrHosts],
    input  logic [DataWidth/8-1:0]    host_be_i     [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i  [NrHosts],
    output logic                      host_rvalid_o [NrHosts],
    output logic [DataWidth-1:0]      host_rdata_o  [NrHosts],
    output logic                      host_err_o    [NrHosts],

    output logic                      device_req_o    [NrDevices],
    output logic [AddressWidth-1:0]   device_addr_o   [NrDevices],
    output logic                      device_we_o     [NrDevices],
    output logic [DataWidth/8-1:0]    device_be_o     [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o  [NrDevices],
    input  logic                      device_rvalid_i [NrDevices],
    input  logic [DataWidth-1:0]      device_rdata_i  [NrDevices],
    input  logic                      device_err_i    [NrDevices],

    input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

    localparam int unsigned HostW = idx_width(NrHosts);
    localparam int unsigned DevW  = idx_width(NrDevices);
    localparam int unsigned BeW   = DataWidth / 8;

    logic [NrHosts-1:0]      req_vec;
    logic [NrHosts-1:0]      gnt_vec;
    logic [HostW-1:0]        win_idx;
    logic                    win_valid;

    logic [AddressWidth-1:0] win_addr;
    logic                    win_we;
    logic [BeW-1:0]          win_be;
    logic [DataWidth-1:0]    win_wdata;

    logic [DevW-1:0]         dev_sel;
    logic                    fwd_ok;

    logic                    valid_d, valid_q;
    logic [HostW-1:0]        host_sel_d, host_sel_q;
    logic [DevW-1:0]         dev_sel_d, dev_sel_q;

    logic                    rsp_rvalid;
    logic [DataWidth-1:0]    rsp_rdata;
    logic                    rsp_err;

`ifdef BUS_DECODE_ERR_EN
    logic                    dev_hit;
    logic                    dec_err_d, dec_err_q;
`endif

    always_comb begin
        for (int h = 0; h < int'(NrHosts); h++) begin
            req_vec[h]    = host_req_i[h];
            host_gnt_o[h] = gnt_vec[h];
        end
    end

    bus_prio_arb #(
        .N    (NrHosts),
        .IdxW (HostW)
    ) u_arb (
        .req_i   (req_vec),
        .gnt_o   (gnt_vec),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    always_comb begin
        win_addr  = '0;
        win_we    = 1'b0;
        win_be    = '0;
        win_wdata = '0;
        for (int h = 0; h < int'(NrHosts); h++) begin
            if (win_idx == HostW'(h)) begin
                win_addr  = host_addr_i[h];
                win_we    = host_we_i[h];
                win_be    = host_be_i[h];
                win_wdata = host_wdata_i[h];
            end
        end
    end

    // Lowest-indexed matching device wins; with no match the select stays at device 0.
    always_comb begin
        dev_sel = '0;
`ifdef BUS_DECODE_ERR_EN
        dev_hit = 1'b0;
`endif
        for (int d = int'(NrDevices) - 1; d >= 0; d--) begin
            if ((win_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
                dev_sel = DevW'(d);
`ifdef BUS_DECODE_ERR_EN
                dev_hit = 1'b1;
`endif
            end
        end
    end

`ifdef BUS_DECODE_ERR_EN
    assign fwd_ok = dev_hit;
`else
    assign fwd_ok = 1'b1;
`endif

    always_comb begin
        for (int d = 0; d < int'(NrDevices); d++) begin
            device_req_o[d]   = win_valid && fwd_ok && (dev_sel == DevW'(d));
            device_addr_o[d]  = win_addr;
            device_we_o[d]    = win_we;
            device_be_o[d]    = win_be;
            device_wdata_o[d] = win_wdata;
        end
    end

    always_comb begin
        valid_d    = win_valid;
        host_sel_d = win_valid ? win_idx : host_sel_q;
        dev_sel_d  = win_valid ? dev_sel : dev_sel_q;
`ifdef BUS_DECODE_ERR_EN
        dec_err_d  = win_valid && !dev_hit;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q    <= 1'b0;
            host_sel_q <= '0;
            dev_sel_q  <= '0;
`ifdef BUS_DECODE_ERR_EN
            dec_err_q  <= 1'b0;
`endif
        end else begin
            valid_q    <= valid_d;
            host_sel_q <= host_sel_d;
            dev_sel_q  <= dev_sel_d;
`ifdef BUS_DECODE_ERR_EN
            dec_err_q  <= dec_err_d;
`endif
        end
    end

    // A response only reaches a host while a transaction is pending, so anything in flight across reset is dropped.
    always_comb begin
        rsp_rvalid = 1'b0;
        rsp_rdata  = '0;
        rsp_err    = 1'b0;
        for (int d = 0; d < int'(NrDevices); d++) begin
            if (dev_sel_q == DevW'(d)) begin
                rsp_rvalid = device_rvalid_i[d];
                rsp_rdata  = device_rdata_i[d];
                rsp_err    = device_err_i[d];
            end
        end
`ifdef BUS_DECODE_ERR_EN
        if (dec_err_q) begin
            rsp_rvalid = 1'b1;
            rsp_rdata  = '0;
            rsp_err    = 1'b1;
        end
`endif
        for (int h = 0; h < int'(NrHosts); h++) begin
            host_rvalid_o[h] = 1'b0;
            host_rdata_o[h]  = '0;
            host_err_o[h]    = 1'b0;
            if (valid_q && (host_sel_q == HostW'(h))) begin
                host_rvalid_o[h] = rsp_rvalid;
                host_rdata_o[h]  = rsp_rdata;
                host_err_o[h]    = rsp_err;
            end
        end
    end

endmodule

// File: tb/tb_bus_interconnect.sv
// Directed scoreboard bench for bus_interconnect with two hosts and the three-device system map.
module tb_bus_interconnect;
    import bus_pkg::*;

    localparam int NH = 2;
    localparam int ND = 3;

`ifdef BUS_DECODE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        int          host;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        host_req    [NH];
    logic        host_gnt    [NH];
    logic [31:0] host_addr   [NH];
    logic        host_we     [NH];
    logic [3:0]  host_be     [NH];
    logic [31:0] host_wdata  [NH];
    logic        host_rvalid [NH];
    logic [31:0] host_rdata  [NH];
    logic        host_err    [NH];

    logic        device_req    [ND];
    logic [31:0] device_addr   [ND];
    logic        device_we     [ND];
    logic [3:0]  device_be     [ND];
    logic [31:0] device_wdata  [ND];
    logic        device_rvalid [ND];
    logic [31:0] device_rdata  [ND];
    logic        device_err    [ND];
    logic [31:0] cfg_base      [ND];
    logic [31:0] cfg_mask      [ND];

    logic [31:0] dev_data [ND] = '{32'hDEAD_BEEF, 32'h5151_0001, 32'h7177_0002};

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    assign cfg_base[0] = RAM_BASE;
    assign cfg_mask[0] = RAM_MASK;
    assign cfg_base[1] = SIMCTRL_BASE;
    assign cfg_mask[1] = SIMCTRL_MASK;
    assign cfg_base[2] = TIMER_BASE;
    assign cfg_mask[2] = TIMER_MASK;

    bus_interconnect #(
        .NrDevices    (ND),
        .NrHosts      (NH),
        .DataWidth    (32),
        .AddressWidth (32)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .host_req_i           (host_req),
        .host_gnt_o           (host_gnt),
        .host_addr_i          (host_addr),
        .host_we_i            (host_we),
        .host_be_i            (host_be),
        .host_wdata_i         (host_wdata),
        .host_rvalid_o        (host_rvalid),
        .host_rdata_o         (host_rdata),
        .host_err_o           (host_err),
        .device_req_o         (device_req),
        .device_addr_o        (device_addr),
        .device_we_o          (device_we),
        .device_be_o          (device_be),
        .device_wdata_o       (device_wdata),
        .device_rvalid_i      (device_rvalid),
        .device_rdata_i       (device_rdata),
        .device_err_i         (device_err),
        .cfg_device_addr_base (cfg_base),
        .cfg_device_addr_mask (cfg_mask)
    );

    // Device model: answers exactly one cycle after a request; flags an error when addr[7:4] == 4'hE.
    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            device_rvalid[d] <= device_req[d];
            device_rdata[d]  <= device_req[d] ? dev_data[d] : 32'h0;
            device_err[d]    <= device_req[d] && (device_addr[d][7:4] == 4'hE);
        end
    end

    function automatic int tbDecode(input logic [31:0] a);
        if ((a & RAM_MASK) == RAM_BASE)         return 0;
        if ((a & SIMCTRL_MASK) == SIMCTRL_BASE) return 1;
        if ((a & TIMER_MASK) == TIMER_BASE)     return 2;
        return -1;
    endfunction

    task automatic compareValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drives the hosts, checks the combinational request path, queues the response.
    task automatic applyStimulus(input logic [1:0] req,
                                 input logic [31:0] a0, input logic we0, input logic [31:0] wd0,
                                 input logic [31:0] a1, input logic we1, input logic [31:0] wd1);
        int          w;
        int          target;
        logic [31:0] wa;
        logic        wwe;
        logic [3:0]  wbe;
        logic [31:0] wwd;
        exp_t        e;
        host_req[0] = req[0];  host_addr[0] = a0;  host_we[0] = we0;  host_be[0] = 4'hF;  host_wdata[0] = wd0;
        host_req[1] = req[1];  host_addr[1] = a1;  host_we[1] = we1;  host_be[1] = 4'h3;  host_wdata[1] = wd1;
        #1;
        w = req[0] ? 0 : (req[1] ? 1 : -1);
        wa  = (w == 1) ? a1  : a0;
        wwe = (w == 1) ? we1 : we0;
        wbe = (w == 1) ? 4'h3 : 4'hF;
        wwd = (w == 1) ? wd1 : wd0;
        target = tbDecode(wa);
        if (target < 0 && !ERR_EN) target = 0;
        for (int h = 0; h < NH; h++)
            compareValue($sformatf("gnt[%0d] addr=%h", h, wa), 32'(host_gnt[h]), 32'(w == h));
        for (int d = 0; d < ND; d++)
            compareValue($sformatf("device_req[%0d] addr=%h", d, wa), 32'(device_req[d]),
                         32'(w >= 0 && target == d));
        if (w >= 0) begin
            compareValue("device_addr", device_addr[2], wa);
            compareValue("device_we", 32'(device_we[1]), 32'(wwe));
            compareValue("device_be", 32'(device_be[0]), 32'(wbe));
            compareValue("device_wdata", device_wdata[2], wwd);
            e.host  = w;
            e.rdata = (target >= 0) ? dev_data[target] : 32'h0;
            e.err   = (target >= 0) ? (wa[7:4] == 4'hE) : 1'b1;
            sb.push_back(e);
        end
        @(posedge clk);
    endtask

    // Called at a negedge: compares every host's response against the queued expectation (or idle).
    task automatic checkOutput();
        exp_t e;
        bit   have;
        have = (sb.size() > 0);
        if (have) e = sb.pop_front();
        for (int h = 0; h < NH; h++) begin
            compareValue($sformatf("rvalid[%0d]", h), 32'(host_rvalid[h]), 32'(have && e.host == h));
            compareValue($sformatf("rdata[%0d]", h), host_rdata[h],
                         (have && e.host == h) ? e.rdata : 32'h0);
            compareValue($sformatf("err[%0d]", h), 32'(host_err[h]), 32'(have && e.host == h && e.err));
        end
    endtask

    initial begin
        for (int h = 0; h < NH; h++) begin
            host_req[h] = 1'b0;  host_addr[h] = '0;  host_we[h] = 1'b0;
            host_be[h]  = '0;    host_wdata[h] = '0;
        end
        repeat (2) @(posedge clk);

        // Reset state with idle hosts
        @(negedge clk); checkOutput(); applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk); checkOutput();
        rst_n = 1'b1;

        @(negedge clk); checkOutput(); applyStimulus(2'b01, 32'h0020_0010, 0, 0, 0, 0, 0);
        @(negedge clk); checkOutput(); applyStimulus(2'b01, 32'h0003_0004, 1, 32'h1234_5678, 0, 0, 0);
        @(negedge clk); checkOutput(); applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);

        // Both hosts contend; host 1 holds its request until granted
        @(negedge clk); checkOutput(); applyStimulus(2'b11, 32'h0002_0000, 0, 0, 32'h0002_0000, 1, 32'hAAAA_5555);
        @(negedge clk); checkOutput(); applyStimulus(2'b10, 0, 0, 0, 32'h0002_0000, 1, 32'hAAAA_5555);

        // Back-to-back RAM, Timer, RAM, then SimCtrl from host 1
        @(negedge clk); checkOutput(); applyStimulus(2'b01, 32'h0020_0100, 0, 0, 0, 0, 0);
        @(negedge clk); checkOutput(); applyStimulus(2'b01, 32'h0003_0008, 1, 32'hCAFE_0001, 0, 0, 0);
        @(negedge clk); checkOutput(); applyStimulus(2'b01, 32'h0020_00E0, 0, 0, 0, 0, 0);
        @(negedge clk); checkOutput(); applyStimulus(2'b10, 0, 0, 0, 32'h0002_00E4, 0, 0);

        // Unmapped address
        @(negedge clk); checkOutput(); applyStimulus(2'b01, 32'h1000_0000, 0, 0, 0, 0, 0);
        @(negedge clk); checkOutput(); applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);

        // Reset between request and response drops the response
        @(negedge clk); checkOutput(); applyStimulus(2'b01, 32'h0020_0020, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        sb.delete();
        @(negedge clk); checkOutput(); applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        @(negedge clk); checkOutput(); applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk); checkOutput(); applyStimulus(2'b10, 0, 0, 0, 32'h0003_0010, 0, 0);
        @(negedge clk); checkOutput(); applyStimulus(2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk); checkOutput();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
